// File: rtl/mmio_uart_tx_pkg.sv
// Shared register map, STATUS bit positions and TX FSM encodings for mmio_uart_tx.
// UART_TX_PARITY_EN adds the PARITY state encoding.
package mmio_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_EMPTY   = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory port as seen by the UART: select, direction, word index, data.
interface mmio_uart_tx_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, we, addr, wdata, input rdata);
  modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO; a push while full is accepted only if a pop frees a slot.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_next;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + CW'(1);
    else if (do_pop && !do_push) count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count_next;
      full   <= count_next == CW'(DEPTH);
      empty  <= count_next == '0;
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data-memory port.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit after the data bits).
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIV_RST    = 434
) (
  input  logic          clk,
  input  logic          rst,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          tx_busy
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic             push, pop, full, empty;
  logic [7:0]       fifo_dout;
  logic [CW-1:0]    count;
  logic [DIV_W-1:0] divisor, baud_cnt;
  logic             ovf;
  tx_state_e        state;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif
  logic             wr, rd, bit_end, frame_end, ovf_evt, busy_next;
  logic [31:0]      status_word, rdata_next;
  logic             unused_wdata;

  assign wr        = bus.sel && bus.we;
  assign rd        = bus.sel && !bus.we;
  assign push      = wr && (bus.addr == REG_TXDATA);
  assign pop       = (state == S_IDLE) && !empty;
  assign bit_end   = baud_cnt == '0;
  assign frame_end = (state == S_STOP) && bit_end;
  assign ovf_evt   = push && full && !pop;
  // Busy as it will be after this edge, so the flop is not a cycle late.
  assign busy_next = ((state != S_IDLE) && !frame_end) || !empty || push;
  assign unused_wdata = ^bus.wdata;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.wdata[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    status_word                              = '0;
    status_word[ST_BUSY]                     = tx_busy;
    status_word[ST_FULL]                     = full;
    status_word[ST_EMPTY]                    = empty;
    status_word[ST_OVF]                      = ovf;
    status_word[ST_CNT_LSB +: 8]             = 8'(count);
    case (bus.addr)
      REG_STATUS:  rdata_next = status_word;
      REG_BAUDDIV: rdata_next = 32'(divisor);
      default:     rdata_next = '0;
    endcase
  end

  // Bus-visible registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata <= '0;
      divisor   <= DIV_W'(DIV_RST);
      ovf       <= 1'b0;
      tx_busy   <= 1'b0;
    end else begin
      if (rd) bus.rdata <= rdata_next;
      if (wr && (bus.addr == REG_BAUDDIV))
        divisor <= (bus.wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : bus.wdata[DIV_W-1:0];
      if (ovf_evt)                               ovf <= 1'b1;
      else if (rd && (bus.addr == REG_STATUS))   ovf <= 1'b0;
      tx_busy <= busy_next;
    end
  end

  // Frame sequencer; baud counter reloads at every bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else if (state == S_IDLE) begin
      if (!empty) begin
        state    <= S_START;
        tx       <= 1'b0;
        shift    <= fifo_dout;
        bit_idx  <= '0;
        baud_cnt <= divisor - DIV_W'(1);
`ifdef UART_TX_PARITY_EN
        parity   <= ^fifo_dout;
`endif
      end
    end else if (!bit_end) begin
      baud_cnt <= baud_cnt - DIV_W'(1);
    end else begin
      baud_cnt <= divisor - DIV_W'(1);
      case (state)
        S_START: begin
          state <= S_DATA;
          tx    <= shift[0];
        end
        S_DATA: begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state <= S_PARITY;
            tx    <= parity;
`else
            state <= S_STOP;
            tx    <= 1'b1;
`endif
          end else begin
            bit_idx <= bit_idx + 3'd1;
            shift   <= shift >> 1;
            tx      <= shift[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          state <= S_STOP;
          tx    <= 1'b1;
        end
`endif
        S_STOP: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed + randomized bench for mmio_uart_tx; a line-level receiver decodes frames from tx.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  logic tx, tx_busy;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.FIFO_DEPTH(8), .DIV_W(16), .DIV_RST(434)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         rx_div = 434;
  int         cyc = 0;
  logic [7:0] rx_data_q[$];
  int         rx_start_q[$];
  bit         rx_ok_q[$];
  logic [7:0] exp_q[$];

  // Receiver state
  bit         rx_active = 1'b0;
  int         rx_pos = 0;
  int         rx_start = 0;
  logic [10:0] rx_bits = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Ideal receiver: samples each bit at its centre using the divisor the bench programmed.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) rx_active = 1'b0;
      else begin
        if (!rx_active && tx === 1'b0) begin
          rx_active = 1'b1;
          rx_pos    = 0;
          rx_start  = cyc;
        end
        if (rx_active) begin
          if (rx_pos % rx_div == rx_div / 2) begin
            rx_bits[rx_pos / rx_div] = tx;
            if (rx_pos / rx_div == NBITS - 1) begin
              rx_active = 1'b0;
              rx_data_q.push_back(rx_bits[8:1]);
              rx_start_q.push_back(rx_start);
              rx_ok_q.push_back(rx_bits[0] == 1'b0 && rx_bits[NBITS-1] == 1'b1 &&
                                (NBITS == 10 || rx_bits[9] == ^rx_bits[8:1]));
            end
          end
          rx_pos++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] lv;
    lv      = '1;
    lv[0]   = 1'b0;
    lv[8:1] = b;
    if (NBITS == 11) lv[9] = ^b;
    return lv;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = v;
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    @(negedge clk);
    bus.sel = 1'b0;
    d = bus.rdata;
  endtask

  task automatic set_div(input int v);
    bus_write(REG_BAUDDIV, 32'(v));
    rx_div = (v == 0) ? 1 : v;
  endtask

  task automatic rx_clear();
    rx_data_q.delete(); rx_start_q.delete(); rx_ok_q.delete(); exp_q.delete();
  endtask

  // Called right after the push: checks every line sample of the frame and the busy drop.
  task automatic check_wave(input logic [7:0] b, input int div, input string tag);
    logic [10:0] lv;
    int bad;
    lv = frame_bits(b);
    for (int k = 0; k < NBITS; k++) begin
      bad = 0;
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        if (tx !== lv[k]) bad++;
      end
      chk($sformatf("%s_bit%0d_bad_samples", tag, k), 32'(bad), 32'd0);
    end
    chk({tag, "_busy_last"}, 32'(tx_busy), 32'd1);
    @(negedge clk);
    chk({tag, "_busy_end"}, 32'(tx_busy), 32'd0);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_in_time"}, 32'(n < limit), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_rx(input string tag, input int div);
    int n;
    chk({tag, "_frames"}, 32'(rx_data_q.size()), 32'(exp_q.size()));
    n = (rx_data_q.size() < exp_q.size()) ? rx_data_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(rx_data_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s_framing%0d", tag, i), 32'(rx_ok_q[i]), 32'd1);
      if (i > 0)
        chk($sformatf("%s_spacing%0d", tag, i), 32'(rx_start_q[i] - rx_start_q[i-1]),
            32'(NBITS * div + 1));
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    int          div, n, low;

    rst = 1'b1;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Register map after reset
    bus_read(REG_STATUS, d);  chk("status_reset", d, 32'h0000_0004);
    bus_read(REG_BAUDDIV, d); chk("div_reset", d, 32'd434);
    repeat (2) @(negedge clk);
    chk("rdata_hold", bus.rdata, 32'd434);
    bus_read(REG_TXDATA, d);  chk("txdata_reads_0", d, 32'd0);
    bus_read(2'd3, d);        chk("reserved_reads_0", d, 32'd0);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(REG_STATUS, d);  chk("reserved_write_ignored", d, 32'h0000_0004);

    // Single byte, exact waveform
    set_div(4);
    bus_read(REG_BAUDDIV, d); chk("div_4", d, 32'd4);
    rx_clear();
    bus_write(REG_TXDATA, 32'hA5); exp_q.push_back(8'hA5);
    check_wave(8'hA5, 4, "a5");
    compare_rx("a5_rx", 4);

    // Nine back-to-back pushes while the first is popped: all sent, no overflow
    rx_clear();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      bus_write(REG_TXDATA, 32'(b));
    end
    bus_read(REG_STATUS, d); chk("status_9push", d, 32'h0000_0803);
    wait_idle(2000, "nine");
    compare_rx("nine_rx", 4);

    // One byte in flight, then ten pushes: last two dropped, ovf set then cleared by read
    rx_clear();
    b = 8'($urandom);
    exp_q.push_back(b);
    bus_write(REG_TXDATA, 32'(b));
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if (i < 8) exp_q.push_back(b);
      bus_write(REG_TXDATA, 32'(b));
    end
    bus_read(REG_STATUS, d); chk("status_ovf", d, 32'h0000_080B);
    bus_read(REG_STATUS, d); chk("status_ovf_cleared", d, 32'h0000_0803);
    wait_idle(2000, "ovf");
    compare_rx("ovf_rx", 4);

    // Divisor 0 is stored as 1; a 0x00 frame occupies 10 clocks of line time
    set_div(0);
    bus_read(REG_BAUDDIV, d); chk("div_zero_as_1", d, 32'd1);
    rx_clear();
    bus_write(REG_TXDATA, 32'h00); exp_q.push_back(8'h00);
    check_wave(8'h00, 1, "div1");
    compare_rx("div1_rx", 1);

    // Randomized bursts with random divisors and short gaps
    for (int r = 0; r < 5; r++) begin
      div = $urandom_range(1, 6);
      set_div(div);
      rx_clear();
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(REG_TXDATA, 32'(b));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle(3000, $sformatf("rnd%0d", r));
      compare_rx($sformatf("rnd%0d_rx", r), div);
    end

    // Reset during data bit 3 abandons the frame
    set_div(4);
    rx_clear();
    bus_write(REG_TXDATA, 32'h00);
    repeat (18) @(negedge clk);
    chk("pre_reset_tx_low", 32'(tx), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("reset_mid_tx", 32'(tx), 32'd1);
    chk("reset_mid_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_div = 434;
    bus_read(REG_STATUS, d);  chk("status_after_reset", d, 32'h0000_0004);
    bus_read(REG_BAUDDIV, d); chk("div_after_reset", d, 32'd434);
    low = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    chk("no_partial_frame", 32'(low), 32'd0);
    chk("no_frames_rx", 32'(rx_data_q.size()), 32'd0);

    // Parity-sensitive byte: with parity a 1 bit precedes stop, otherwise stop follows bit 7
    set_div(4);
    rx_clear();
    bus_write(REG_TXDATA, 32'h07); exp_q.push_back(8'h07);
    check_wave(8'h07, 4, "b07");
    compare_rx("b07_rx", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
